seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment scan bus (seg/w_sel) driven by the team's digit-scan display drivers.
- Samples the scanned bus on the system clock, decodes each digit's segment pattern back to a BCD nibble, and reassembles the 8-digit value.
- Publishes a per-frame value plus a debounced "stable" value.
- Used as an in-fabric self-check and loopback monitor for display/counter blocks.

Parameters:
- SETTLE, 2: cycles w_sel must hold unchanged before its digit is captured (1..15).
- STABLE_FRAMES, 2: consecutive identical, error-free frames required to update value (1..15).
- TIMEOUT, 1024: cycles without any capture before the monitor declares the bus dead (>= 2).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset. Synchronous, active-high.
- seg  in  8  segment pattern, active-low, bit7 = dp, bit6..0 = g..a.
- w_sel  in  8  digit select, one-hot active-high, bit n = digit n (digit 0 = least significant).
- frame_value  out  32  last completed frame, 8 nibbles, digit n at [4n+3:4n].
- frame_done  out  1  1-cycle pulse when frame_value updates.
- digit_err  out  8  per-digit error flags of the last completed frame.
- value  out  32  debounced stable value.
- value_valid  out  1  value holds a confirmed reading.
- value_update  out  1  1-cycle pulse when value changes or first becomes valid.
- sel_err  out  1  1-cycle pulse on a capture point with non-one-hot w_sel.
- timeout  out  1  level: no capture for TIMEOUT cycles.

Behaviour:
- Reset: every output is 0, and all internal counters and masks are cleared. clr asserted mid-frame discards the partial frame. First capture is possible SETTLE+1 cycles after clr deasserts.
- Input stage: seg and w_sel are registered once (seg_q, sel_q). All logic below uses the registered copies.
- Settle counter:
  - Cleared when sel_q differs from the previous sel_q; otherwise increments, saturating at SETTLE.
  - Capture point is the single cycle where the count reaches SETTLE-1. That is one capture per select dwell.
  - A dwell shorter than SETTLE produces no capture.
- Capture, sel_q one-hot:
  - Decode seg_q[6:0] ignoring dp: C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9 (full byte shown with dp off).
  - Any other pattern stores nibble F and sets the error bit for that digit.
  - Sets the captured-mask bit. Recapturing an already-captured digit overwrites the nibble and error bit and does not raise an error.
- Capture, sel_q not one-hot (zero or multiple bits): no store; sel_err pulses.
- Frame completion:
  - When the mask is all ones, on the next cycle: frame_value and digit_err load, frame_done pulses, mask clears.
  - A capture in that same cycle lands in the new frame.
- Stability:
  - On frame_done, the completed frame is compared with the previous completed frame. An identical, error-free frame increments match_cnt, saturating at STABLE_FRAMES.
  - An error-free frame that differs sets match_cnt = 1. A frame with any error sets match_cnt = 0.
  - When match_cnt reaches STABLE_FRAMES and the frame differs from value (or value_valid = 0), the cycle after frame_done: value loads, value_valid = 1, value_update pulses.
  - With STABLE_FRAMES = 1, every error-free frame qualifies.
- Timeout:
  - Idle counter clears on each capture, saturating at TIMEOUT.
  - On reaching TIMEOUT: timeout = 1, mask clears, match_cnt clears, value_valid = 0. value keeps its last contents.
  - Next capture clears timeout.
- Errored frames never change value or value_valid.

Optional Feature:
- Macro: SEG_SCAN_HEX_DECODE_EN.
- Defined: additional patterns decode as hex digits: 88→A, 83→B, C6→C, A1→D, 86→E, 8E→F. These are not errors. F is only an error for unmatched patterns.
- Undefined: those patterns are errors (nibble F, error bit set). Only 0–9 are legal.

Test Plan:
1. Reset, then scan 2,0,2,1,0,5,2,7 (digits 7..0), 4 cycles per digit, 3 frames, SETTLE=2, STABLE_FRAMES=2 -> frame_value=32'h20210527 on each frame_done; value=32'h20210527, value_valid=1, value_update single pulse after frame 2.
2. Same scan but digit 3 pattern = 8'hFF -> digit_err=8'h08, frame_value[15:12]=F, value unchanged, match_cnt reset; clean frames after -> value updates after 2 clean frames.
3. w_sel=8'h03 held 4 cycles mid-frame -> one sel_err pulse, no capture, frame completes on later valid digits.
4. Dwell of 1 cycle per digit with SETTLE=2 -> no captures, frame_done never pulses; after TIMEOUT cycles timeout=1, value_valid=0.
5. clr pulsed after 5 digits captured -> all outputs 0; next full scan yields frame_done only after all 8 new digits are captured.
6. Pattern 8'h88 on digit 0 -> nibble A and no error with SEG_SCAN_HEX_DECODE_EN; nibble F and digit_err=8'h01 without it.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive side of the 7-segment digit-scan bus: decodes each scanned digit, rebuilds 8-digit frames
// and publishes a debounced value. Optional macro SEG_SCAN_HEX_DECODE_EN accepts A-F glyphs.
module seg_scan_decoder #(
    parameter int unsigned SETTLE        = 2,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  seg,
    input  logic [7:0]  w_sel,
    output logic [31:0] frame_value,
    output logic        frame_done,
    output logic [7:0]  digit_err,
    output logic [31:0] value,
    output logic        value_valid,
    output logic        value_update,
    output logic        sel_err,
    output logic        timeout
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

`ifdef SEG_SCAN_HEX_DECODE_EN
    localparam bit HexEn = 1'b1;
`else
    localparam bit HexEn = 1'b0;
`endif

    // Returns {error, nibble}; patterns are active-low g..a with dp stripped.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = HexEn ? 5'h0A : 5'h1F;
            7'h03:   r = HexEn ? 5'h0B : 5'h1F;
            7'h46:   r = HexEn ? 5'h0C : 5'h1F;
            7'h21:   r = HexEn ? 5'h0D : 5'h1F;
            7'h06:   r = HexEn ? 5'h0E : 5'h1F;
            7'h0E:   r = HexEn ? 5'h0F : 5'h1F;
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    logic [7:0]       seg_q, sel_q, sel_prev_q;
    logic [3:0]       settle_q, settle_d;
    logic [7:0]       mask_q, mask_d;
    logic [31:0]      nib_q, nib_d;
    logic [7:0]       err_q, err_d;
    logic [3:0]       match_q;
    logic [IdleW-1:0] idle_q, idle_d;

    logic [31:0]      frame_value_q, value_q;
    logic [7:0]       digit_err_q;
    logic             frame_done_q, value_valid_q, value_update_q, sel_err_q, timeout_q;

    logic             sel_onehot, cap_point, cap_ok, frame_full;
    logic [4:0]       dec;

    assign sel_onehot = (sel_q != 8'h00) && ((sel_q & (sel_q - 8'h01)) == 8'h00);
    // One capture per dwell: the count passes SETTLE-1 only once before saturating.
    assign cap_point  = (sel_q == sel_prev_q) && (settle_q == 4'(SETTLE - 1));
    assign cap_ok     = cap_point && sel_onehot;
    assign frame_full = (mask_q == 8'hFF);
    assign dec        = decode_seg(seg_q[6:0]);

    always_comb begin
        settle_d = settle_q;
        if (sel_q != sel_prev_q) begin
            settle_d = 4'd0;
        end else if (settle_q < 4'(SETTLE)) begin
            settle_d = settle_q + 4'd1;
        end
    end

    always_comb begin
        nib_d = nib_q;
        err_d = err_q;
        for (int i = 0; i < 8; i++) begin
            if (cap_ok && sel_q[i]) begin
                nib_d[4*i +: 4] = dec[3:0];
                err_d[i]        = dec[4];
            end
        end
    end

    // A capture coinciding with frame completion starts the next frame.
    always_comb begin
        mask_d = frame_full ? 8'h00 : mask_q;
        if (cap_ok) begin
            mask_d = mask_d | sel_q;
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (cap_ok) begin
            idle_d = '0;
        end else if (idle_q < IdleW'(TIMEOUT)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            seg_q          <= 8'h00;
            sel_q          <= 8'h00;
            sel_prev_q     <= 8'h00;
            settle_q       <= 4'd0;
            mask_q         <= 8'h00;
            nib_q          <= 32'h0;
            err_q          <= 8'h00;
            match_q        <= 4'd0;
            idle_q         <= '0;
            frame_value_q  <= 32'h0;
            digit_err_q    <= 8'h00;
            frame_done_q   <= 1'b0;
            value_q        <= 32'h0;
            value_valid_q  <= 1'b0;
            value_update_q <= 1'b0;
            sel_err_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            seg_q          <= seg;
            sel_q          <= w_sel;
            sel_prev_q     <= sel_q;
            settle_q       <= settle_d;
            mask_q         <= mask_d;
            nib_q          <= nib_d;
            err_q          <= err_d;
            idle_q         <= idle_d;
            frame_done_q   <= 1'b0;
            value_update_q <= 1'b0;
            sel_err_q      <= cap_point && !sel_onehot;

            if (frame_full) begin
                frame_value_q <= nib_q;
                digit_err_q   <= err_q;
                frame_done_q  <= 1'b1;
                if (err_q != 8'h00) begin
                    match_q <= 4'd0;
                end else if (nib_q == frame_value_q) begin
                    if (match_q < 4'(STABLE_FRAMES)) begin
                        match_q <= match_q + 4'd1;
                    end
                end else begin
                    match_q <= 4'd1;
                end
            end

            // match_q was refreshed together with frame_done_q, so it reflects this frame.
            if (frame_done_q && (match_q == 4'(STABLE_FRAMES)) &&
                ((frame_value_q != value_q) || !value_valid_q)) begin
                value_q        <= frame_value_q;
                value_valid_q  <= 1'b1;
                value_update_q <= 1'b1;
            end

            if (idle_d == IdleW'(TIMEOUT)) begin
                timeout_q     <= 1'b1;
                mask_q        <= 8'h00;
                match_q       <= 4'd0;
                value_valid_q <= 1'b0;
            end else if (cap_ok) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign frame_value  = frame_value_q;
    assign frame_done   = frame_done_q;
    assign digit_err    = digit_err_q;
    assign value        = value_q;
    assign value_valid  = value_valid_q;
    assign value_update = value_update_q;
    assign sel_err      = sel_err_q;
    assign timeout      = timeout_q;

endmodule
